div3bits_seq: RTL and testbench

DIV3BITS_SEQ -- requirements
Module: div3bits_seq

---
 rtl/div3bits_seq_if.sv | 28 ++
 rtl/div3bits_seq.sv | 204 ++++++++++++++++++++
 tb/tb_div3bits_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div3bits_seq_if.sv
// Request/result bundle for the sequential restoring divider.
// start/dividend/divisor are sampled only on the capture edge in IDLE; results are held until the next done.
interface div3bits_seq_if #(
    parameter int WIDTH = 3
);
    localparam int CW = $clog2(2 * WIDTH + 1);

    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_zero;
    logic [CW-1:0]          CountOut;
    logic [1:0]             state_dbg;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, CountOut, state_dbg
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, CountOut, state_dbg
    );
endinterface

// File: rtl/div3bits_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Control FSM and datapath are separate submodules joined by the top.
module div3bits_seq_fsm #(
    parameter int WIDTH = 3,
    parameter int CW    = $clog2(2 * WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          div_is_zero,
    output logic [1:0]    state,
    output logic [CW-1:0] count,
    output logic          load,
    output logic          load_zero,
    output logic          step,
    output logic          last,
    output logic          busy,
    output logic          done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * WIDTH - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load      = 1'b0;
        load_zero = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    if (div_is_zero) begin
                        load_zero = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                step    = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state = state_q;
    assign count = count_q;
    assign busy  = (state_q == S_CALC);
    assign done  = (state_q == S_DONE);
endmodule

module div3bits_seq_dp #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               load_zero,
    input  logic               step,
    input  logic               last,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero
);
    // Dividend bits leave the top of dvd while quotient bits enter at the bottom,
    // so after 2*WIDTH steps the register holds the whole quotient.
    logic [2*WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   pr_q, pr_d;
    logic [2*WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dz_q, dz_d;

    logic [WIDTH:0]     pr_shift;
    logic               ge;
    logic [WIDTH-1:0]   pr_step;
    logic [2*WIDTH-1:0] dvd_step;

    always_comb begin
        pr_shift = {pr_q, dvd_q[2*WIDTH-1]};
        ge       = (pr_shift >= {1'b0, dsr_q});
        // The stored remainder is always below the divisor, so it fits in WIDTH bits.
        pr_step  = ge ? WIDTH'(pr_shift - {1'b0, dsr_q}) : pr_shift[WIDTH-1:0];
        dvd_step = {dvd_q[2*WIDTH-2:0], ge};

        dvd_d = dvd_q;
        dsr_d = dsr_q;
        pr_d  = pr_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dz_d  = dz_q;
        if (load) begin
            dvd_d = dividend;
            dsr_d = divisor;
            pr_d  = '0;
            if (load_zero) begin
                quo_d = '1;
                rem_d = dividend[WIDTH-1:0];
                dz_d  = 1'b1;
            end
        end else if (step) begin
            dvd_d = dvd_step;
            pr_d  = pr_step;
            if (last) begin
                quo_d = dvd_step;
                rem_d = pr_step;
                dz_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd_q <= '0;
            dsr_q <= '0;
            pr_q  <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            dvd_q <= dvd_d;
            dsr_q <= dsr_d;
            pr_q  <= pr_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dz_q  <= dz_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule

module div3bits_seq #(
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    div3bits_seq_if.slave  bus
);
    localparam int CW = $clog2(2 * WIDTH + 1);

    logic load, load_zero, step, last;
    logic div_is_zero;

    assign div_is_zero = (bus.divisor == '0);

    div3bits_seq_fsm #(.WIDTH(WIDTH), .CW(CW)) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .start       (bus.start),
        .div_is_zero (div_is_zero),
        .state       (bus.state_dbg),
        .count       (bus.CountOut),
        .load        (load),
        .load_zero   (load_zero),
        .step        (step),
        .last        (last),
        .busy        (bus.busy),
        .done        (bus.done)
    );

    div3bits_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_zero (load_zero),
        .step      (step),
        .last      (last),
        .dividend  (bus.dividend),
        .divisor   (bus.divisor),
        .quotient  (bus.quotient),
        .remainder (bus.remainder),
        .div_zero  (bus.div_zero)
    );
endmodule

// File: tb/tb_div3bits_seq.sv
// Directed and randomized checks of div3bits_seq against an arithmetic reference model.
module tb_div3bits_seq;
  localparam int W = 3;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  div3bits_seq_if #(.WIDTH(W)) bus ();

  div3bits_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // reference model: plain integer division
  function automatic void ref_div(input int dvd, input int dsr, output int q, output int r);
    if (dsr == 0) begin
      q = (1 << (2 * W)) - 1;
      r = dvd % (1 << W);
    end else begin
      q = dvd / dsr;
      r = dvd % dsr;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after the capture edge; follows the operation through its done pulse.
  task automatic wait_result(input int dvd, input int dsr);
    int q_e, r_e, cyc, busy_cyc;
    ref_div(dvd, dsr, q_e, r_e);
    cyc = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, (dsr == 0) ? 0 : 2 * W);
    check("busy_cycles", busy_cyc, (dsr == 0) ? 0 : 2 * W);
    check("quotient", bus.quotient, q_e);
    check("remainder", bus.remainder, r_e);
    check("div_zero", bus.div_zero, (dsr == 0) ? 1 : 0);
    check("busy_at_done", bus.busy, 0);
    check("count_out", bus.CountOut, (dsr == 0) ? 0 : 2 * W);
    @(posedge clk);
    #1;
    check("done_single", bus.done, 0);
    check("quotient_hold", bus.quotient, q_e);
    check("remainder_hold", bus.remainder, r_e);
  endtask

  // driver: one-cycle start, inputs scrambled right after capture
  task automatic run_op(input int dvd, input int dsr);
    @(negedge clk);
    bus.dividend = dvd[2*W-1:0];
    bus.divisor  = dsr[W-1:0];
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 6'($urandom_range(0, 63));
    bus.divisor  = 3'($urandom_range(0, 7));
    wait_result(dvd, dsr);
  endtask

  initial begin
    int sweep_q[$];
    int dones, q_seen, r_seen, cyc;

    // reset state, start held during reset
    reset        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 6'd45;
    bus.divisor  = 3'd6;
    #3;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_div_zero", bus.div_zero, 0);
    check("rst_count", bus.CountOut, 0);
    @(posedge clk);
    #1;
    check("rst_busy_edge", bus.busy, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("accept_first_edge", bus.busy, 1);
    bus.start = 1'b0;
    wait_result(45, 6);

    // directed operands
    run_op(63, 7);
    run_op(5, 7);
    run_op(20, 0);
    run_op(12, 4);
    run_op(0, 1);
    run_op(63, 1);
    run_op(0, 0);

    // start pulsed during CALC with other operands
    @(negedge clk);
    bus.dividend = 6'd45;
    bus.divisor  = 3'd6;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.dividend = 6'd10;
    bus.divisor  = 3'd2;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones  = 0;
    q_seen = 0;
    r_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        dones++;
        q_seen = int'(bus.quotient);
        r_seen = int'(bus.remainder);
      end
    end
    check("calc_start_dones", dones, 1);
    check("calc_start_quotient", q_seen, 7);
    check("calc_start_remainder", r_seen, 3);

    // start held high: next op begins at the first edge back in IDLE
    @(negedge clk);
    bus.dividend = 6'd45;
    bus.divisor  = 3'd6;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("held_latency", cyc, 2 * W);
    check("held_quotient", bus.quotient, 7);
    bus.dividend = 6'd12;
    bus.divisor  = 3'd4;
    @(posedge clk);
    #1;
    check("held_idle_busy", bus.busy, 0);
    check("held_idle_done", bus.done, 0);
    @(posedge clk);
    #1;
    check("held_restart_busy", bus.busy, 1);
    bus.start = 1'b0;
    wait_result(12, 4);

    // reset during CALC aborts with no done pulse
    @(negedge clk);
    bus.dividend = 6'd45;
    bus.divisor  = 3'd6;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_div_zero", bus.div_zero, 0);
    check("abort_count", bus.CountOut, 0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(45, 6);

    // all nonzero operand pairs, shuffled
    for (int d = 1; d < 8; d++)
      for (int n = 0; n < 64; n++)
        sweep_q.push_back(n * 8 + d);
    for (int i = sweep_q.size() - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = sweep_q[i];
      sweep_q[i] = sweep_q[j];
      sweep_q[j] = t;
    end
    foreach (sweep_q[k]) run_op(sweep_q[k] / 8, sweep_q[k] % 8);

    // random operations including zero divisors
    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 63), $urandom_range(0, 7));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
